build_info_tx: RTL and testbench

Transmit side of the build-identity path. On request, it snapshots `core_id`, `commit_id` and `dirty`, then sends them as a framed byte stream over a valid/ready interface. The receiving end decodes and displays the identity. It sits beside the identity consumer in the xs-bugcase harness, so simulated and synthesized builds report the same commit information through one serial channel.

---
 rtl/build_info_tx.sv | 141 ++++++++++++++
 tb/tb_build_info_tx.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/build_info_tx.sv
// Build-identity transmitter: snapshots core_id/commit_id/dirty on req and streams them as a byte frame.
// Optional trailing XOR checksum byte enabled by defining BUILD_INFO_TX_CSUM_EN.
module build_info_tx #(
  parameter logic [7:0] HEADER = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic [31:0] core_id,
  input  logic [39:0] commit_id,
  input  logic        dirty,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_last,
  input  logic        tx_ready,
  output logic        busy,
  output logic        done,
  output logic        req_drop
);

  localparam int DATA_LEN = 11;
`ifdef BUILD_INFO_TX_CSUM_EN
  localparam int FRAME_LEN = DATA_LEN + 1;
`else
  localparam int FRAME_LEN = DATA_LEN;
`endif
  localparam logic [3:0] LAST_IDX  = 4'(FRAME_LEN - 1);
  localparam logic [3:0] FRAME_CNT = 4'(FRAME_LEN);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t      state_q;
  logic [3:0]  idx_q;
  logic [3:0]  idx_d;
  logic [31:0] core_q;
  logic [39:0] commit_q;
  logic        dirty_q;
  logic        tx_valid_q;
  logic [7:0]  tx_data_q;
  logic [7:0]  data_d;
  logic        tx_last_q;
  logic        done_q;
  logic        req_drop_q;

  // Frame content is derived only from the shadow registers, never the live inputs.
  logic [8*DATA_LEN-1:0] data_vec;
  logic [7:0]            byte_tbl [FRAME_LEN];

  assign data_vec = {HEADER, core_q, commit_q, 7'b0, dirty_q};

  generate
    for (genvar gi = 0; gi < DATA_LEN; gi++) begin : g_bytes
      assign byte_tbl[gi] = data_vec[8*(DATA_LEN-1-gi) +: 8];
    end
  endgenerate

`ifdef BUILD_INFO_TX_CSUM_EN
  logic [7:0] csum;

  always_comb begin
    csum = 8'h00;
    for (int k = 0; k < DATA_LEN; k++) begin
      csum = csum ^ data_vec[8*k +: 8];
    end
  end

  assign byte_tbl[DATA_LEN] = csum;
`endif

  assign idx_d = idx_q + 4'd1;

  always_comb begin
    data_d = 8'h00;
    if (idx_d < FRAME_CNT) begin
      data_d = byte_tbl[idx_d];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= 4'd0;
      core_q     <= 32'h0;
      commit_q   <= 40'h0;
      dirty_q    <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
      tx_last_q  <= 1'b0;
      done_q     <= 1'b0;
      req_drop_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req) begin
            core_q     <= core_id;
            commit_q   <= commit_id;
            dirty_q    <= dirty;
            idx_q      <= 4'd0;
            tx_valid_q <= 1'b1;
            tx_data_q  <= HEADER;
            tx_last_q  <= 1'b0;
            req_drop_q <= 1'b0;
            state_q    <= SEND;
          end
        end
        SEND: begin
          if (req) begin
            req_drop_q <= 1'b1;
          end
          // tx_valid is always high here, so tx_ready alone is the handshake.
          if (tx_ready) begin
            if (idx_q == LAST_IDX) begin
              state_q    <= IDLE;
              tx_valid_q <= 1'b0;
              tx_data_q  <= 8'h00;
              tx_last_q  <= 1'b0;
              done_q     <= 1'b1;
            end else begin
              idx_q     <= idx_d;
              tx_data_q <= data_d;
              tx_last_q <= (idx_d == LAST_IDX);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_data_q;
  assign tx_last  = tx_last_q;
  assign busy     = (state_q == SEND);
  assign done     = done_q;
  assign req_drop = req_drop_q;

endmodule

// File: tb/tb_build_info_tx.sv
// Self-checking bench for build_info_tx: frame-level reference model plus literal frame tables.
module tb_build_info_tx;

`ifdef BUILD_INFO_TX_CSUM_EN
  localparam int FLEN = 12;
`else
  localparam int FLEN = 11;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic [31:0] core_id = 32'h0;
  logic [39:0] commit_id = 40'h0;
  logic        dirty = 1'b0;
  logic        tx_ready = 1'b1;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_last;
  logic        busy;
  logic        done;
  logic        req_drop;

  logic        req5 = 1'b0;
  logic [31:0] core5 = 32'h0;
  logic [39:0] commit5 = 40'h0;
  logic        dirty5 = 1'b0;
  logic        tx_ready5 = 1'b1;
  logic        tx_valid5;
  logic [7:0]  tx_data5;
  logic        tx_last5;
  logic        busy5;
  logic        done5;
  logic        req_drop5;

  build_info_tx u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .core_id(core_id), .commit_id(commit_id),
    .dirty(dirty), .tx_valid(tx_valid), .tx_data(tx_data), .tx_last(tx_last),
    .tx_ready(tx_ready), .busy(busy), .done(done), .req_drop(req_drop)
  );

  build_info_tx #(.HEADER(8'h5A)) u_dut5a (
    .clk(clk), .rst_n(rst_n), .req(req5), .core_id(core5), .commit_id(commit5),
    .dirty(dirty5), .tx_valid(tx_valid5), .tx_data(tx_data5), .tx_last(tx_last5),
    .tx_ready(tx_ready5), .busy(busy5), .done(done5), .req_drop(req_drop5)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_basic [12] = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h03, 8'h12,
                                 8'h34, 8'h56, 8'h78, 8'h9A, 8'h01, 8'h35};
  logic [7:0] exp_5a    [12] = '{8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                                 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h5A};

  // Reference model state
  logic       m_busy = 1'b0;
  logic       m_done = 1'b0;
  logic       m_drop = 1'b0;
  int         m_pos = 0;
  logic [7:0] m_frame [12];

  logic [7:0] rx_q [$];
  logic [7:0] rx5_q [$];
  int         busy_cycles = 0;
  int         done_cnt = 0;
  int         rdy_mode = 0;
  int         stall_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: frame bytes built from the captured fields with plain shifts.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_busy = 1'b0;
        m_done = 1'b0;
        m_drop = 1'b0;
        m_pos  = 0;
      end else begin
        m_done = 1'b0;
        if (!m_busy) begin
          if (req) begin
            logic [7:0] cs;
            m_frame[0] = 8'hA5;
            for (int i = 0; i < 4; i++) m_frame[1+i] = 8'((core_id >> (8*(3-i))) & 32'hFF);
            for (int i = 0; i < 5; i++) m_frame[5+i] = 8'((commit_id >> (8*(4-i))) & 40'hFF);
            m_frame[10] = dirty ? 8'h01 : 8'h00;
            cs = 8'h00;
            for (int i = 0; i < 11; i++) cs = cs ^ m_frame[i];
            m_frame[11] = cs;
            m_pos  = 0;
            m_busy = 1'b1;
            m_drop = 1'b0;
          end
        end else begin
          if (req) m_drop = 1'b1;
          if (tx_ready) begin
            if (m_pos == FLEN - 1) begin
              m_busy = 1'b0;
              m_done = 1'b1;
            end else begin
              m_pos++;
            end
          end
        end
      end
    end
  end

  // Compare process: every cycle, mid-period.
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("tx_valid", tx_valid, m_busy);
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("req_drop", req_drop, m_drop);
      if (m_busy) begin
        chk("tx_data", tx_data, m_frame[m_pos]);
        chk("tx_last", tx_last, m_pos == FLEN - 1);
      end else begin
        chk("tx_last_idle", tx_last, 1'b0);
      end
      if (tx_valid && tx_ready) rx_q.push_back(tx_data);
      if (tx_valid5 && tx_ready5) rx5_q.push_back(tx_data5);
      if (busy) busy_cycles++;
      if (done) done_cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
    if (rdy_mode == 0) begin
      tx_ready = 1'b1;
    end else if (m_busy && m_pos == 4 && stall_cnt < 5) begin
      tx_ready = 1'b0;
      stall_cnt++;
    end else begin
      tx_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic start_frame(input logic [31:0] c, input logic [39:0] m, input logic d);
    core_id   = c;
    commit_id = m;
    dirty     = d;
    req = 1'b1;
    step();
    req = 1'b0;
  endtask

  task automatic finish_frame(input int budget);
    int n = 0;
    while (m_busy && n < budget) begin
      step();
      n++;
    end
    if (m_busy) begin
      checks++;
      errors++;
      $display("FAIL frame_timeout actual=busy required=idle within %0d cycles", budget);
    end
  endtask

  task automatic check_rx(input string name, input logic [7:0] exp [12]);
    chk({name, "_len"}, rx_q.size(), FLEN);
    for (int i = 0; i < FLEN; i++) begin
      if (i < rx_q.size()) chk({name, "_byte"}, rx_q[i], exp[i]);
    end
    $display("frame %s: %0d bytes received", name, rx_q.size());
  endtask

  task automatic advance_to(input int pos);
    int n = 0;
    while (m_pos != pos && n < 100) begin
      step();
      n++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    step();
    step();
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_tx_last", tx_last, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_req_drop", req_drop, 1'b0);
    rst_n = 1'b1;
    step();

    // Basic frame
    rx_q.delete();
    busy_cycles = 0;
    done_cnt = 0;
    start_frame(32'h3, 40'h123456789A, 1'b1);
    chk("first_byte_hdr", tx_data, 8'hA5);
    finish_frame(50);
    step();
    step();
    check_rx("basic", exp_basic);
    chk("basic_busy_cycles", busy_cycles, FLEN);
    chk("basic_done_count", done_cnt, 1);

    // Backpressure
    rx_q.delete();
    rdy_mode = 1;
    stall_cnt = 0;
    start_frame(32'h3, 40'h123456789A, 1'b1);
    finish_frame(300);
    rdy_mode = 0;
    step();
    check_rx("backpressure", exp_basic);
    chk("stall_count", stall_cnt, 5);

    // Input change after the header handshake
    rx_q.delete();
    start_frame(32'h3, 40'h123456789A, 1'b1);
    step();
    core_id = 32'hFFFFFFFF;
    dirty   = 1'b0;
    finish_frame(50);
    step();
    check_rx("midchange", exp_basic);

    // Requests while busy, then a request in the done cycle
    rx_q.delete();
    start_frame(32'h3, 40'h123456789A, 1'b1);
    advance_to(6);
    req = 1'b1;
    step();
    req = 1'b0;
    chk("drop_after_byte6", req_drop, 1'b1);
    advance_to(FLEN - 1);
    req = 1'b1;
    step();
    req = 1'b0;
    chk("done_after_last", done, 1'b1);
    chk("drop_after_last", req_drop, 1'b1);
    chk("idle_after_last", busy, 1'b0);
    req = 1'b1;
    step();
    req = 1'b0;
    chk("b2b_busy", busy, 1'b1);
    chk("b2b_header", tx_data, 8'hA5);
    chk("b2b_drop_cleared", req_drop, 1'b0);
    finish_frame(50);
    step();
    step();
    step();
    chk("no_extra_frame", tx_valid, 1'b0);
    chk("two_frames_bytes", rx_q.size(), 2 * FLEN);

    // Asynchronous reset mid-frame
    rx_q.delete();
    start_frame(32'h3, 40'h123456789A, 1'b1);
    advance_to(3);
    req = 1'b1;
    step();
    req = 1'b0;
    advance_to(7);
    chk("drop_before_reset", req_drop, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("arst_tx_valid", tx_valid, 1'b0);
    chk("arst_tx_data", tx_data, 8'h00);
    chk("arst_tx_last", tx_last, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_done", done, 1'b0);
    chk("arst_req_drop", req_drop, 1'b0);
    step();
    rst_n = 1'b1;
    rx_q.delete();
    done_cnt = 0;
    step();
    chk("no_done_after_abort", done_cnt, 0);
    start_frame(32'h3, 40'h123456789A, 1'b1);
    finish_frame(50);
    step();
    check_rx("after_reset", exp_basic);
    chk("after_reset_done", done_cnt, 1);

    // HEADER parameter instance
    rx5_q.delete();
    req5 = 1'b1;
    step();
    req5 = 1'b0;
    chk("hdr5a_first", tx_data5, 8'h5A);
    repeat (FLEN + 3) step();
    chk("hdr5a_len", rx5_q.size(), FLEN);
    for (int i = 0; i < FLEN; i++) begin
      if (i < rx5_q.size()) chk("hdr5a_byte", rx5_q[i], exp_5a[i]);
    end
    $display("frame hdr5a: %0d bytes received", rx5_q.size());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
